// File: rtl/mem_stage.sv
// Memory access stage: sequences one data-memory access per load/store through
// IDLE -> WAIT -> DONE, aligning store lanes and extracting load data.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_res,
  input  logic [31:0] ex_rs2data,
  input  logic [1:0]  ex_wbsel,
  input  logic [31:0] ex_pcp4,
  input  logic [4:0]  ex_rdaddr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic [1:0]  mem_wbsel,
  output logic [31:0] mem_dmem_out,
  output logic [31:0] mem_alu_res,
  output logic [31:0] mem_pcp4,
  output logic [4:0]  mem_rdaddr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] load_buf_q, load_buf_d;
  logic        memop_s;
  logic        fault_s;
  logic        bad_f3_s;
  logic        misalign_s;

  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] rdata);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (off)
      2'b00:   byte_v = rdata[7:0];
      2'b01:   byte_v = rdata[15:8];
      2'b10:   byte_v = rdata[23:16];
      2'b11:   byte_v = rdata[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
      3'b100:  res_v = {24'h000000, byte_v};
      3'b001:  res_v = {{16{half_v[15]}}, half_v};
      3'b101:  res_v = {16'h0000, half_v};
      3'b010:  res_v = rdata;
      default: res_v = 32'h0000_0000;
    endcase
    return res_v;
  endfunction

  // Classify the request: illegal size, conflicting controls or misalignment.
  always_comb begin
    memop_s  = ex_memread | ex_memwrite;
    bad_f3_s = (ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111);
    case (ex_funct3)
      3'b001, 3'b101: misalign_s = ex_alu_res[0];
      3'b010:         misalign_s = (ex_alu_res[1:0] != 2'b00);
      default:        misalign_s = 1'b0;
    endcase
    fault_s = memop_s & ((ex_memread & ex_memwrite) | bad_f3_s | misalign_s);
  end

  // Next-state and load-buffer capture; ack only matters while waiting.
  always_comb begin
    state_d    = state_q;
    load_buf_d = load_buf_q;
    case (state_q)
      S_IDLE: begin
        if (memop_s && !fault_s) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          state_d    = S_DONE;
          load_buf_d = load_extract(ex_funct3, ex_alu_res[1:0], dmem_rdata);
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and load buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      load_buf_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      load_buf_q <= load_buf_d;
    end
  end

  // Store lane steering; the pipeline holds EX/MEM while waiting, so these stay stable.
  always_comb begin
    dmem_addr = {ex_alu_res[31:2], 2'b00};
    dmem_we   = ex_memwrite;
    if (ex_memwrite) begin
      case (ex_funct3[1:0])
        2'b00: begin
          dmem_wdata = {4{ex_rs2data[7:0]}};
          dmem_be    = 4'b0001 << ex_alu_res[1:0];
        end
        2'b01: begin
          dmem_wdata = {2{ex_rs2data[15:0]}};
          dmem_be    = ex_alu_res[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          dmem_wdata = ex_rs2data;
          dmem_be    = 4'b1111;
        end
      endcase
    end else begin
      dmem_wdata = 32'h0000_0000;
      dmem_be    = 4'b1111;
    end
  end

  // Handshake and writeback outputs decoded from state; reset forces a bubble.
  always_comb begin
    dmem_req     = 1'b0;
    mem_stall    = 1'b0;
    mem_fault    = 1'b0;
    mem_dmem_out = 32'h0000_0000;
    if (rst) begin
      dmem_req     = 1'b0;
      mem_stall    = 1'b0;
      mem_fault    = 1'b0;
      mem_dmem_out = 32'h0000_0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          mem_stall = memop_s & ~fault_s;
          mem_fault = fault_s;
        end
        S_WAIT: begin
          dmem_req  = 1'b1;
          mem_stall = 1'b1;
        end
        S_DONE:  mem_dmem_out = load_buf_q;
        default: mem_stall = 1'b0;
      endcase
    end
    mem_rdaddr = (mem_stall | mem_fault | rst) ? 5'd0 : ex_rdaddr;
  end

  assign mem_alu_res = ex_alu_res;
  assign mem_pcp4    = ex_pcp4;
  assign mem_wbsel   = ex_wbsel;

endmodule
